mantissa_alu: RTL and testbench

MANTISSA_ALU -- requirements
Module: mantissa_alu

---
 rtl/fp_alu_pkg.sv | 14 +
 rtl/mag_addsub.sv | 37 +++
 rtl/mantissa_alu.sv | 124 ++++++++++++
 tb/tb_mantissa_alu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Opcodes and FSM state encoding shared by the FP-unit blocks.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDSUB = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mag_addsub.sv
// Combinational sign-magnitude adder/subtractor; sign_b is the already-effective sign.
module mag_addsub #(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic [WIDTH-1:0] mag,
  output logic             carry,
  output logic             sign
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    mag   = '0;
    carry = 1'b0;
    sign  = 1'b0;
    if (sign_a == sign_b) begin
      mag   = sum[WIDTH-1:0];
      carry = sum[WIDTH];
      sign  = sign_a;
    end else if (a > b) begin
      mag  = a - b;
      sign = sign_a;
    end else if (b > a) begin
      mag  = b - a;
      sign = sign_b;
    end
    // Equal magnitudes with opposite signs fall through to a positive zero.
  end

endmodule

// File: rtl/mantissa_alu.sv
// Mantissa ALU: single-cycle sign-magnitude add/sub and WIDTH-cycle shift-add multiply.
module mantissa_alu
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [1:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             sign_out,
  output logic             op_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;       // doubles as the low product half while multiplying
  logic [WIDTH-1:0] acc_hi;
  logic             sa;
  logic             sb_eff;
  logic [1:0]       op_q;

  logic [WIDTH-1:0] as_mag;
  logic             as_carry;
  logic             as_sign;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  mag_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a      (opa),
    .b      (opb),
    .sign_a (sa),
    .sign_b (sb_eff),
    .mag    (as_mag),
    .carry  (as_carry),
    .sign   (as_sign)
  );

  // One shift-add step: add the multiplicand if the current multiplier bit is set, then shift right.
  assign step_sum = {1'b0, acc_hi} + (opb[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
  assign next_hi  = step_sum[WIDTH:1];
  assign next_lo  = {step_sum[0], opb[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      // NOTE: operand/accumulator registers are deliberately not reset; they are always loaded on accept.
      state     <= ST_IDLE;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      sign_out  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opa    <= input_a;
            opb    <= input_b;
            sa     <= sign_a;
            sb_eff <= (operation == OP_SUB) ? ~sign_b : sign_b;
            op_q   <= operation;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= (operation == OP_MUL) ? ST_MUL : ST_ADDSUB;
          end
        end
        ST_ADDSUB: begin
          result_hi <= '0;
          if (op_q == OP_ILL) begin
            result   <= '0;
            carry    <= 1'b0;
            sign_out <= 1'b0;
            op_err   <= 1'b1;
          end else begin
            result   <= as_mag;
            carry    <= as_carry;
            sign_out <= as_sign;
            op_err   <= 1'b0;
          end
          state <= ST_DONE;
        end
        ST_MUL: begin
          acc_hi <= next_hi;
          opb    <= next_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= next_lo;
            result_hi <= next_hi;
            carry     <= 1'b0;
            sign_out  <= sa ^ sb_eff;
            op_err    <= 1'b0;
            cnt       <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_alu.sv
// Self-checking bench for mantissa_alu: directed vector table, corner sequences, random vs. model.
module tb_mantissa_alu;
  import fp_alu_pkg::*;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         sign_a;
  logic         sign_b;
  logic [1:0]   operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         sign_out;
  logic         op_err;

  int checks = 0;
  int errors = 0;

  mantissa_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_a   (input_a),
    .input_b   (input_b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .sign_out  (sign_out),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sa;
    logic         sb;
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         c;
    logic         s;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from signed-value arithmetic and a full-width product.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb,
                       output logic [W-1:0] r, output logic [W-1:0] rh,
                       output logic c, output logic s, output logic e, output int lat);
    longint unsigned mask = (64'd1 << W) - 1;
    longint unsigned p;
    longint va, vb, t;
    logic sbe;
    r = '0; rh = '0; c = 1'b0; s = 1'b0; e = 1'b0; lat = 1;
    sbe = (op == OP_SUB) ? ~sb : sb;
    if (op == OP_ILL) begin
      e = 1'b1;
    end else if (op == OP_MUL) begin
      p   = longint'(a) * longint'(b);
      r   = W'(p & mask);
      rh  = W'((p >> W) & mask);
      s   = sa ^ sb;
      lat = W;
    end else if (sa == sbe) begin
      p = longint'(a) + longint'(b);
      r = W'(p & mask);
      c = p[W];
      s = sa;
    end else begin
      va = sa  ? -longint'(a) : longint'(a);
      vb = sbe ? -longint'(b) : longint'(b);
      t  = va + vb;
      if (t < 0) begin
        r = W'(-t);
        s = 1'b1;
      end else begin
        r = W'(t);
      end
    end
  endtask

  // Issues one operation, scrambling inputs and out_ready while busy; returns edges until out_valid.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1; operation = op; input_a = a; input_b = b; sign_a = sa; sign_b = sb;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      input_a   = W'($urandom);
      input_b   = W'($urandom);
      sign_a    = 1'($urandom);
      sign_b    = 1'($urandom);
      operation = 2'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); lat++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                               input logic c, input logic s, input logic e);
    check({tag, ".result"},    64'(result),    64'(r));
    check({tag, ".result_hi"}, 64'(result_hi), 64'(rh));
    check({tag, ".carry"},     64'(carry),     64'(c));
    check({tag, ".sign_out"},  64'(sign_out),  64'(s));
    check({tag, ".op_err"},    64'(op_err),    64'(e));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, er, erh;
    logic         rsa, rsb, ec, es, ee;
    int           elat;

    vecs[0] = '{OP_ADD, 26'd3,         26'd5,         1'b0, 1'b0, 26'd8,       26'd0,         1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{OP_ADD, 26'h3FFFFFF,   26'd1,         1'b0, 1'b0, 26'd0,       26'd0,         1'b1, 1'b0, 1'b0, 1};
    vecs[2] = '{OP_SUB, 26'd3,         26'd5,         1'b0, 1'b0, 26'd2,       26'd0,         1'b0, 1'b1, 1'b0, 1};
    vecs[3] = '{OP_SUB, 26'd5,         26'd5,         1'b0, 1'b0, 26'd0,       26'd0,         1'b0, 1'b0, 1'b0, 1};
    vecs[4] = '{OP_MUL, 26'h2000000,   26'd4,         1'b1, 1'b0, 26'd0,       26'd2,         1'b0, 1'b1, 1'b0, W};
    vecs[5] = '{OP_ILL, 26'd7,         26'd9,         1'b1, 1'b1, 26'd0,       26'd0,         1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{OP_ADD, 26'd1,         26'd2,         1'b1, 1'b1, 26'd3,       26'd0,         1'b0, 1'b1, 1'b0, 1};
    vecs[7] = '{OP_MUL, 26'd0,         26'd5,         1'b1, 1'b0, 26'd0,       26'd0,         1'b0, 1'b1, 1'b0, W};
    vecs[8] = '{OP_SUB, 26'd2,         26'd7,         1'b1, 1'b1, 26'd5,       26'd0,         1'b0, 1'b0, 1'b0, 1};
    vecs[9] = '{OP_MUL, 26'h3FFFFFF,   26'h3FFFFFF,   1'b0, 1'b0, 26'd1,       26'h3FFFFFE,   1'b0, 1'b0, 1'b0, W};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; operation = OP_ADD;
    input_a = '0; input_b = '0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check_outputs("reset", '0, '0, 1'b0, 1'b0, 1'b0);

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, lat);
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'(vecs[i].lat));
      check_outputs($sformatf("vec%0d", i), vecs[i].r, vecs[i].rh, vecs[i].c, vecs[i].s, vecs[i].e);
      release_result();
    end

    // Hold the result with out_ready low for five cycles
    do_op(OP_ADD, 26'd3, 26'd5, 1'b0, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      input_a = W'($urandom); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check($sformatf("hold%0d.in_ready", k),  64'(in_ready),  64'd0);
      check($sformatf("hold%0d.out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d.result", k),    64'(result),    64'd8);
    end
    in_valid = 1'b0;
    release_result();
    check("hold.release.in_ready",  64'(in_ready),  64'd1);
    check("hold.release.out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply aborts it with no result ever presented
    in_valid = 1'b1; operation = OP_MUL; input_a = 26'h123; input_b = 26'h456;
    sign_a = 1'b0; sign_b = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mulrst.out_valid", 64'(out_valid), 64'd0);
    check("mulrst.in_ready",  64'(in_ready),  64'd1);
    check_outputs("mulrst", '0, '0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mulrst.no_partial", 64'(seen), 64'd0);
    do_op(OP_ADD, 26'd1, 26'd1, 1'b0, 1'b0, lat);
    check("mulrst.add.latency", 64'(lat), 64'd1);
    check_outputs("mulrst.add", 26'd2, '0, 1'b0, 1'b0, 1'b0);
    release_result();

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra  = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 26'h3FFFFFF;
        2: rb = W'($urandom_range(0, 15));
        default: rb = W'($urandom);
      endcase
      rsa = 1'($urandom); rsb = 1'($urandom);
      model(rop, ra, rb, rsa, rsb, er, erh, ec, es, ee, elat);
      do_op(rop, ra, rb, rsa, rsb, lat);
      check($sformatf("rnd%0d.latency", n), 64'(lat), 64'(elat));
      check_outputs($sformatf("rnd%0d", n), er, erh, ec, es, ee);
      release_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
